// File: rtl/paicore_send_nch_if.sv
// Input frame stream bundle for the N-channel PAICORE sender.
// A beat transfers on a rising clock edge where both s_axis_tvalid and
// s_axis_tready are 1; the master holds tdata/tlast stable while tvalid is
// high and tready is low, and tready never waits on tvalid.
interface paicore_send_nch_if;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;

    modport master (
        output s_axis_tdata,
        output s_axis_tlast,
        output s_axis_tvalid,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tlast,
        input  s_axis_tvalid,
        output s_axis_tready
    );
endinterface

// File: rtl/paicore_send_nch.sv
// N-channel PAICORE sender: buffers a 64-bit frame stream in a FIFO,
// dispatches words by broadcast or in-order round-robin over a channel mask,
// and serialises each word into two 32-bit four-phase req/ack transfers.
module paicore_send_nch #(
    parameter int NUM_CH      = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   s_axis_aclk,
    input  logic                   s_axis_aresetn,
    input  logic                   fork_enable,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic [31:0]            send_len,
    output logic [31:0]            data_cnt,
    output logic [31:0]            tlast_cnt,
    paicore_send_nch_if.slave      s_axis,
    input  logic [NUM_CH-1:0]      acknowledge,
    output logic [NUM_CH*32-1:0]   dout,
    output logic [NUM_CH-1:0]      request,
    output logic                   busy,
    output logic                   o_tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ_LO, ST_REL_LO, ST_REQ_HI, ST_REL_HI
    } ch_state_e;

    // ---------------- input FIFO ----------------
    logic [63:0]  mem_q [FIFO_DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         rdy_en_q;
    logic [31:0]  data_cnt_q, tlast_cnt_q;
    logic         fifo_full, fifo_empty, wr_en, pop;
    logic [63:0]  fifo_head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // tready is held low through reset and the first cycle after it
    assign s_axis.s_axis_tready = rdy_en_q & ~fifo_full;
    assign wr_en     = s_axis.s_axis_tvalid & s_axis.s_axis_tready;
    assign fifo_head = mem_q[rd_ptr_q[AW-1:0]];
    assign data_cnt  = data_cnt_q;
    assign tlast_cnt = tlast_cnt_q;

    // FIFO storage array; contents are don't-care until written
    always_ff @(posedge s_axis_aclk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s_axis.s_axis_tdata;
    end

    // FIFO pointers, tready enable and input beat counters
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rdy_en_q    <= 1'b0;
            data_cnt_q  <= '0;
            tlast_cnt_q <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (wr_en) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                data_cnt_q <= data_cnt_q + 32'd1;
                if (s_axis.s_axis_tlast) tlast_cnt_q <= tlast_cnt_q + 32'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ---------------- acknowledge synchronisers ----------------
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] ack_s;

    assign ack_s = sync_q[SYNC_STAGES-1];

    // multi-flop synchroniser for the asynchronous chip acknowledges
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= acknowledge;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // ---------------- transaction control and dispatch ----------------
    logic              busy_q, fork_q, done_q;
    logic [NUM_CH-1:0] chen_q;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [31:0]       disp_q;
    logic [NUM_CH-1:0] hold_v_q, load_mask, take;
    logic [63:0]       hold_q [NUM_CH];
    ch_state_e         st_q [NUM_CH];
    logic              len_zero, start, eff_fork, may_pop, all_idle, done_cond;
    logic [NUM_CH-1:0] eff_en;
    logic              hi_found, any_found;
    logic [PW-1:0]     hi_idx, lo_idx, sel_idx;

    // A new transaction starts when idle and a word is waiting; on that
    // first edge the live mode/mask are used, afterwards the latched copies.
    assign len_zero  = (send_len == 32'd0);
    assign start     = !busy_q && !fifo_empty && !len_zero;
    assign eff_fork  = busy_q ? fork_q : fork_enable;
    assign eff_en    = busy_q ? chen_q : ch_en;
    assign may_pop   = (busy_q || start) && !fifo_empty && !len_zero &&
                       (disp_q < send_len);
    assign done_cond = busy_q && !len_zero && (disp_q == send_len) &&
                       (hold_v_q == '0) && all_idle;
    assign busy      = busy_q;
    assign o_tx_done = done_q;

    // round-robin target: lowest enabled index >= ptr, else lowest enabled
    always_comb begin
        hi_found  = 1'b0;
        any_found = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (eff_en[j]) begin
                any_found = 1'b1;
                lo_idx    = PW'(j);
                if (j >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(j);
                end
            end
        end
        sel_idx = hi_found ? hi_idx : lo_idx;
        ptr_d   = (sel_idx == PW'(NUM_CH - 1)) ? '0 : sel_idx + 1'b1;
    end

    // pop decision: broadcast waits for every enabled holding register,
    // distribute stalls on the selected channel rather than skipping it
    always_comb begin
        pop       = 1'b0;
        load_mask = '0;
        if (may_pop) begin
            if (eff_fork) begin
                if ((eff_en != '0) && ((eff_en & hold_v_q) == '0)) begin
                    pop       = 1'b1;
                    load_mask = eff_en;
                end
            end else if (any_found && !hold_v_q[sel_idx]) begin
                pop       = 1'b1;
                load_mask = NUM_CH'(1) << sel_idx;
            end
        end
    end

    // transaction latch, dispatched count, pointer and done pulse
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            busy_q <= 1'b0;
            fork_q <= 1'b0;
            chen_q <= '0;
            ptr_q  <= '0;
            disp_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_cond;
            if (len_zero || done_cond) begin
                busy_q <= 1'b0;
                disp_q <= '0;
                ptr_q  <= '0;
            end else begin
                if (start) begin
                    busy_q <= 1'b1;
                    fork_q <= fork_enable;
                    chen_q <= ch_en;
                end
                if (pop) begin
                    disp_q <= disp_q + 32'd1;
                    if (!eff_fork) ptr_q <= ptr_d;
                end
            end
        end
    end

    // ---------------- per-channel serialisers ----------------
    logic [31:0]       shift_q [NUM_CH];
    logic [31:0]       dout_q  [NUM_CH];
    logic [NUM_CH-1:0] req_q;

    // a channel takes its holding word from IDLE, or directly at the end of
    // REL_HI for back-to-back words
    always_comb begin
        take     = '0;
        all_idle = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            take[i] = hold_v_q[i] &&
                      ((st_q[i] == ST_IDLE) || ((st_q[i] == ST_REL_HI) && !ack_s[i]));
            if (st_q[i] != ST_IDLE) all_idle = 1'b0;
        end
    end

    // channel FSMs with registered request/dout, plus holding registers
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]    <= ST_IDLE;
                hold_q[i]  <= '0;
                shift_q[i] <= '0;
                dout_q[i]  <= '0;
            end
            hold_v_q <= '0;
            req_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (take[i]) begin
                    shift_q[i] <= hold_q[i][63:32];
                    dout_q[i]  <= hold_q[i][31:0];
                    req_q[i]   <= 1'b1;
                    st_q[i]    <= ST_REQ_LO;
                end else begin
                    case (st_q[i])
                        ST_REQ_LO: if (ack_s[i]) begin
                            req_q[i] <= 1'b0;
                            st_q[i]  <= ST_REL_LO;
                        end
                        ST_REL_LO: if (!ack_s[i]) begin
                            dout_q[i] <= shift_q[i];
                            req_q[i]  <= 1'b1;
                            st_q[i]   <= ST_REQ_HI;
                        end
                        ST_REQ_HI: if (ack_s[i]) begin
                            req_q[i] <= 1'b0;
                            st_q[i]  <= ST_REL_HI;
                        end
                        ST_REL_HI: if (!ack_s[i]) st_q[i] <= ST_IDLE;
                        default: ;
                    endcase
                end
                if (load_mask[i]) begin
                    hold_q[i]   <= fifo_head;
                    hold_v_q[i] <= 1'b1;
                end else if (take[i]) begin
                    hold_v_q[i] <= 1'b0;
                end
            end
        end
    end

    // pack per-channel data onto the flat output bus
    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_CH; i++) dout[32*i +: 32] = dout_q[i];
    end

    assign request = req_q;

endmodule

// File: tb/tb_paicore_send_nch.sv
// Directed bench for paicore_send_nch: table of transactions plus
// hand-written sequences for stall, mode change, short length and reset.
`timescale 1ns/1ps
module tb_paicore_send_nch;
    localparam int NCH = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              fork_enable;
    logic [NCH-1:0]    ch_en;
    logic [31:0]       send_len;
    logic [31:0]       data_cnt, tlast_cnt;
    logic [NCH-1:0]    ack;
    logic [NCH*32-1:0] dout;
    logic [NCH-1:0]    request;
    logic              busy, o_tx_done;

    paicore_send_nch_if bus ();

    paicore_send_nch #(.NUM_CH(NCH), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .fork_enable    (fork_enable),
        .ch_en          (ch_en),
        .send_len       (send_len),
        .data_cnt       (data_cnt),
        .tlast_cnt      (tlast_cnt),
        .s_axis         (bus),
        .acknowledge    (ack),
        .dout           (dout),
        .request        (request),
        .busy           (busy),
        .o_tx_done      (o_tx_done)
    );

    // ---------------- chip responder / monitor ----------------
    logic [31:0]    got_q [NCH][$];
    logic [NCH-1:0] ack_hold;
    logic [NCH-1:0] req_prev;
    int             dly [NCH];
    int             done_cnt;

    // auto-ack with a 3-cycle delay each phase; records dout on each request rise
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                ack[i]      = 1'b0;
                dly[i]      = 0;
                req_prev[i] = 1'b0;
                got_q[i].delete();
            end
            done_cnt = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (request[i] && !req_prev[i]) got_q[i].push_back(dout[32*i +: 32]);
                req_prev[i] = request[i];
                if (request[i] && !ack[i] && !ack_hold[i]) begin
                    if (dly[i] == 2) begin ack[i] = 1'b1; dly[i] = 0; end
                    else dly[i]++;
                end else if (!request[i] && ack[i]) begin
                    if (dly[i] == 2) begin ack[i] = 1'b0; dly[i] = 0; end
                    else dly[i]++;
                end
            end
            if (o_tx_done) done_cnt++;
        end
    end

    // ---------------- scoreboard helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word(input int n);
        return 64'h1111_0000_0000_0000 * 64'(n) + 64'(n);
    endfunction

    function automatic logic [31:0] lo_half(input int n);
        return 32'(n);
    endfunction

    function automatic logic [31:0] hi_half(input int n);
        return 32'h1111_0000 * 32'(n);
    endfunction

    // expected transfers for a channel: every word in mask, low then high
    task automatic check_channel(input int ch, input logic [31:0] mask, input string tag);
        logic [31:0] exp_q[$];
        exp_q = {};
        for (int n = 0; n < 32; n++) begin
            if (mask[n]) begin
                exp_q.push_back(lo_half(n));
                exp_q.push_back(hi_half(n));
            end
        end
        check($sformatf("%s_ch%0d_count", tag, ch), 64'(got_q[ch].size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q[ch].size(); k++)
            check($sformatf("%s_ch%0d_xfer%0d", tag, ch, k), 64'(got_q[ch][k]), 64'(exp_q[k]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_word(input int n, input bit last, input int tmo, output bit ok);
        int t;
        t = 0;
        bus.s_axis_tdata  = word(n);
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        while (!bus.s_axis_tready && t < tmo) begin
            @(negedge clk);
            t++;
        end
        ok = bus.s_axis_tready;
        if (ok) @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n             = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tdata  = '0;
        ack_hold          = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        check($sformatf("done_pulses_%0d", target), 64'(done_cnt), 64'(target));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic                fork_en;
        logic [NCH-1:0]      en;
        int                  len;
        int                  nw;
        logic [NCH-1:0][31:0] m;   // per-channel bitmask of word indices
    } vec_t;

    vec_t vecs [6];

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int acc;
        int t;

        rst_n             = 1'b0;
        fork_enable       = 1'b0;
        ch_en             = '0;
        send_len          = '0;
        ack_hold          = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tdata  = '0;

        vecs[0] = '{1'b0, 4'b1111, 8, 8, {32'h88, 32'h44, 32'h22, 32'h11}};
        vecs[1] = '{1'b1, 4'b0101, 3, 3, {32'h00, 32'h07, 32'h00, 32'h07}};
        vecs[2] = '{1'b0, 4'b0110, 4, 4, {32'h00, 32'h0A, 32'h05, 32'h00}};
        vecs[3] = '{1'b0, 4'b1000, 2, 2, {32'h03, 32'h00, 32'h00, 32'h00}};
        vecs[4] = '{1'b1, 4'b1111, 2, 2, {32'h03, 32'h03, 32'h03, 32'h03}};
        vecs[5] = '{1'b0, 4'b1011, 5, 5, {32'h04, 32'h00, 32'h12, 32'h09}};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tready",   64'(bus.s_axis_tready), 64'd0);
        check("rst_request",  64'(request), 64'd0);
        check("rst_busy",     64'(busy), 64'd0);
        check("rst_done",     64'(o_tx_done), 64'd0);
        check("rst_data_cnt", 64'(data_cnt), 64'd0);
        check("rst_dout",     64'(dout[63:0]), 64'd0);
        rst_n = 1'b1;
        #1 check("tready_before_edge", 64'(bus.s_axis_tready), 64'd0);
        @(negedge clk);
        check("tready_after_release", 64'(bus.s_axis_tready), 64'd1);

        // latency: handshake at edge k -> request high after edge k+2
        fork_enable = 1'b0;
        ch_en       = 4'b0001;
        send_len    = 32'd1;
        bus.s_axis_tdata  = word(5);
        bus.s_axis_tvalid = 1'b1;
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        check("lat_req_k", 64'(request[0]), 64'd0);
        @(negedge clk);
        check("lat_req_k1", 64'(request[0]), 64'd0);
        @(negedge clk);
        check("lat_req_k2", 64'(request[0]), 64'd1);
        check("lat_dout_lo", 64'(dout[31:0]), 64'd5);
        wait_done(1);
        check_channel(0, 32'h20, "lat");

        // table-driven transactions
        for (int v = 0; v < 6; v++) begin
            do_reset();
            fork_enable = vecs[v].fork_en;
            ch_en       = vecs[v].en;
            send_len    = 32'(vecs[v].len);
            for (int n = 0; n < vecs[v].nw; n++) begin
                send_word(n, n == vecs[v].nw - 1, 100, ok);
                check($sformatf("v%0d_accept%0d", v, n), 64'(ok), 64'd1);
            end
            wait_done(1);
            check($sformatf("v%0d_data_cnt", v), 64'(data_cnt), 64'(vecs[v].nw));
            check($sformatf("v%0d_tlast_cnt", v), 64'(tlast_cnt), 64'd1);
            check($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
            for (int c = 0; c < NCH; c++) check_channel(c, vecs[v].m[c], $sformatf("v%0d", v));
        end

        // distribute stall: channel 1 never acks, nothing skips to channel 3
        do_reset();
        fork_enable = 1'b0;
        ch_en       = 4'b1010;
        send_len    = 32'd20;
        ack_hold    = 4'b0010;
        acc = 0;
        for (int n = 0; n < 24; n++) begin
            send_word(n, 1'b0, 20, ok);
            if (!ok) break;
            acc++;
        end
        check("stall_accepted", 64'(acc), 64'd20);
        check("stall_data_cnt", 64'(data_cnt), 64'd20);
        check("stall_tready", 64'(bus.s_axis_tready), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_ch1_count", 64'(got_q[1].size()), 64'd1);
        check_channel(3, 32'h0000_000A, "stall_pre");
        ack_hold = '0;
        wait_done(1);
        check_channel(1, 32'h0005_5555, "stall_post");
        check_channel(3, 32'h000A_AAAA, "stall_post");

        // mode and mask change mid-transaction
        do_reset();
        fork_enable = 1'b0;
        ch_en       = 4'b1111;
        send_len    = 32'd4;
        send_word(0, 1'b0, 100, ok);
        repeat (2) @(negedge clk);
        fork_enable = 1'b1;
        ch_en       = 4'b0001;
        for (int n = 1; n < 4; n++) send_word(n, 1'b0, 100, ok);
        wait_done(1);
        send_len = 32'd2;
        send_word(4, 1'b0, 100, ok);
        send_word(5, 1'b1, 100, ok);
        wait_done(2);
        check_channel(0, 32'h31, "mode");
        check_channel(1, 32'h02, "mode");
        check_channel(2, 32'h04, "mode");
        check_channel(3, 32'h08, "mode");

        // short length: words beyond send_len wait for the next transaction
        do_reset();
        fork_enable = 1'b0;
        ch_en       = 4'b1111;
        send_len    = 32'd2;
        for (int n = 0; n < 5; n++) send_word(n, n == 4, 100, ok);
        wait_done(2);
        repeat (60) @(negedge clk);
        check("short_done_total", 64'(done_cnt), 64'd2);
        check("short_data_cnt", 64'(data_cnt), 64'd5);
        check("short_tlast_cnt", 64'(tlast_cnt), 64'd1);
        check("short_busy", 64'(busy), 64'd1);
        check_channel(0, 32'h15, "short");
        check_channel(1, 32'h0A, "short");
        check_channel(2, 32'h00, "short");
        check_channel(3, 32'h00, "short");

        // reset while channel 2 is in REQ_HI
        do_reset();
        fork_enable = 1'b0;
        ch_en       = 4'b0100;
        send_len    = 32'd1;
        send_word(7, 1'b1, 100, ok);
        t = 0;
        while (got_q[2].size() < 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("rm_reached_hi", 64'(got_q[2].size()), 64'd2);
        check("rm_req_before", 64'(request[2]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rm_request", 64'(request), 64'd0);
        check("rm_data_cnt", 64'(data_cnt), 64'd0);
        check("rm_tlast_cnt", 64'(tlast_cnt), 64'd0);
        check("rm_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rm_tready_low", 64'(bus.s_axis_tready), 64'd0);
        @(negedge clk);
        check("rm_tready_high", 64'(bus.s_axis_tready), 64'd1);
        repeat (40) @(negedge clk);
        check("rm_no_done", 64'(done_cnt), 64'd0);
        check("rm_request_after", 64'(request), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
